uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer that sits directly downstream of the MiniUart receive unit. It takes each completed byte, `d_out` qualified by the `rs` byte-available flag, and pushes it into a circular FIFO. It then pulses `over_read` back to the receiver to clear `rs`. On the CPU side it offers a first-word-fall-through pop port with empty, full, count and sticky-overrun status, plus a level interrupt.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `IRQ_THRESH`, default 4: fill-level interrupt threshold. Used only with `UART_RXFIFO_THRESH_EN`.
- `TIMEOUT_CYC`, default 16'd2048: idle-timeout in clk cycles. Used only with `UART_RXFIFO_THRESH_EN`.
- `clk`, in, 1: system clock (same clock as receive unit).
- `rst`, in, 1: reset, asynchronous, active-high.
- `rx_data`, in, 8: byte from receiver `d_out`.
- `rx_rs`, in, 1: receiver byte-available flag. Not synchronous to clk.
- `over_read`, out, 1: one-cycle pulse that clears the receiver's `rs`.
- `rd_en`, in, 1: CPU pop request.
- `rd_data`, out, 8: head byte. Valid while `empty`=0.
- `empty`, out, 1: FIFO holds no bytes.
- `full`, out, 1: FIFO holds 2^DEPTH_LOG2 bytes.
- `count`, out, DEPTH_LOG2+1: bytes held (0..2^DEPTH_LOG2).
- `overrun`, out, 1: sticky. Set when a byte was dropped because the FIFO was full.
- `ovr_clr`, in, 1: clears `overrun`.
- `irq`, out, 1: level interrupt.

## Operation
- **Synchronizer:** `rx_rs` passes through a 2-flop synchronizer to give `rs_s`.
- **Capture FSM states:** IDLE, ACK, WAIT_CLR.
  - IDLE → ACK when `rs_s`=1. On that same edge, push `rx_data` if not full. If full, drop the byte and set `overrun`.
  - ACK: `over_read`=1 for exactly this one cycle. Always → WAIT_CLR.
  - WAIT_CLR → IDLE when `rs_s`=0. Otherwise stay, with no further capture.
  - Any other encoding → IDLE.
- **Dropped bytes:** `over_read` is issued even when the byte is dropped, so the receiver never stalls.
- **Storage:** memory 2^DEPTH_LOG2 × 8. `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits and wrap modulo depth. `count` is a separate register.
- **Pop:** `rd_en`=1 and `empty`=0 advances `rd_ptr`. `rd_en` while empty is ignored, with no pointer or count change.
- **Push and pop on the same edge:**
  - Not full: both succeed, `count` is unchanged.
  - Full: the pop succeeds, the push also succeeds (the slot is freed that edge), `overrun` is not set, `count` stays at full.
- **`rd_data`:** equals `mem[rd_ptr]` (fall-through). It is undefined content while empty.
- **`overrun` update:** `ovr_clr` and a set event on the same edge leave `overrun`=1 (set wins).
- **`irq` without the macro:** `irq` = ~`empty` | `overrun`.
- **Reset (any time, including mid-capture):**
  - Pointers, `count`, `overrun` and the synchronizer are cleared.
  - FSM goes to IDLE; `over_read`=0, `irq`=0.
  - If `rx_rs` is still high after reset, that byte is captured again.

## Timing
- **Reset values:** `over_read`=0, `rd_data`=mem[0] (content not reset), `empty`=1, `full`=0, `count`=0, `overrun`=0, `irq`=0.
- **Capture latency:** `rx_rs` sampled high at edge N. Then `rs_s`=1 after edge N+1, the push happens at edge N+2, and `empty` falls, `count` increments and `over_read` rises after edge N+2. `over_read` falls after edge N+3.
- **Minimum spacing:** consecutive captures are at least 2 cycles of `rs_s` low apart. This is guaranteed by UART framing (≥80 clk per byte at 8× oversampling).
- **Pop:** `count`, `empty` and `rd_data` update after the popping edge. `full` clears the same cycle.
- **Flags:** `empty`, `full` and `irq` are decoded from registered `count` and `overrun`, with no added latency.

## Configuration
- **Macro `UART_RXFIFO_THRESH_EN`:**
  - Defined: adds a 16-bit idle timer. The timer resets on every push or pop and on empty. It increments while non-empty and saturates at `TIMEOUT_CYC`.
    - `irq` = (`count` ≥ `IRQ_THRESH`) | (timer == `TIMEOUT_CYC`) | `overrun`.
  - Undefined: no timer, `IRQ_THRESH`/`TIMEOUT_CYC` are ignored, and `irq` = ~`empty` | `overrun`.

## Test plan
- **Reset then single byte:** reset, then `rx_data`=8'hA5 with `rx_rs` high until `over_read`.
  - Required: `over_read` is one pulse 3 edges after `rx_rs`, then `count`=1, `rd_data`=A5, `irq`=1.
  - After `rd_en` for 1 cycle: `empty`=1, `irq`=0 (macro off).
- **Fill to full and overrun:** push 16 bytes 00..0F, then push 8'hFF.
  - Required: `full`=1, `count`=16, `overrun`=1, FF dropped, `over_read` still pulsed.
  - Pops return 00..0F in order.
- **Simultaneous push and pop at full:** FIFO full, `rd_en` on the push edge.
  - Required: `count` stays 16, `overrun` stays 0, the last pop sequence ends with the new byte.
- **Pointer wrap:** 40 push/pop pairs with incrementing data.
  - Required: data order is preserved across the wrap, and `count` never exceeds 1.
- **Reset mid-capture:** assert `rst` during ACK.
  - Required: `over_read`=0 immediately, `count`=0.
  - With `rx_rs` still high after release, the byte is captured once.
- **Threshold and timeout (macro on, `IRQ_THRESH`=4, `TIMEOUT_CYC`=100):**
  - 3 bytes: `irq`=0 until 100 idle cycles, then 1.
  - 4th byte: `irq`=1 immediately after the push.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: receiver capture signals plus the CPU-side pop and status port.
// master drives rx_data/rx_rs/rd_en/ovr_clr; slave is the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic [7:0]          rx_data;
  logic                rx_rs;
  logic                over_read;
  logic                rd_en;
  logic [7:0]          rd_data;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;
  logic                ovr_clr;
  logic                irq;

  modport master (
    output rx_data, rx_rs, rd_en, ovr_clr,
    input  over_read, rd_data, empty, full, count, overrun, irq
  );

  modport slave (
    input  rx_data, rx_rs, rd_en, ovr_clr,
    output over_read, rd_data, empty, full, count, overrun, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the MiniUart receiver: captures bytes into a FWFT circular FIFO.
// Optional macro UART_RXFIFO_THRESH_EN adds fill-threshold and idle-timeout interrupt terms.
module uart_rx_fifo #(
  parameter int          DEPTH_LOG2  = 4,
  parameter int          IRQ_THRESH  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd2048
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_fifo_if.slave      bus,
  output logic [1:0]         dbg_state_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_e;

  logic                  rs_meta_q, rs_s_q;
  state_e                state_q;
  logic                  over_read_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overrun_q;
  logic                  push, pop, wr_ok, drop, empty_w, full_w;

  // rx_rs comes from the receiver's own timing domain; two flops before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta_q <= 1'b0;
      rs_s_q    <= 1'b0;
    end else begin
      rs_meta_q <= bus.rx_rs;
      rs_s_q    <= rs_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      over_read_q <= 1'b0;
    end else begin
      over_read_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rs_s_q) begin
            state_q     <= ST_ACK;
            over_read_q <= 1'b1;
          end
        end
        ST_ACK:      state_q <= ST_WAIT_CLR;
        ST_WAIT_CLR: if (!rs_s_q) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign push    = (state_q == ST_IDLE) && rs_s_q;
  assign pop     = bus.rd_en && !empty_w;
  // A pop on the same edge frees the slot, so a push at full still lands.
  assign wr_ok   = push && (!full_w || pop);
  assign drop    = push && full_w && !pop;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (drop)             overrun_q <= 1'b1;
      else if (bus.ovr_clr) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.rx_data;
  end

`ifdef UART_RXFIFO_THRESH_EN
  logic [15:0] idle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (wr_ok || pop || empty_w) begin
      idle_q <= '0;
    end else if (idle_q != TIMEOUT_CYC) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  assign bus.irq = (count_q >= CNT_W'(IRQ_THRESH)) || (idle_q == TIMEOUT_CYC) || overrun_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYC, 16'(IRQ_THRESH)};
  assign bus.irq    = !empty_w || overrun_q;
`endif

  assign bus.over_read = over_read_q;
  assign bus.rd_data   = mem_q[rd_ptr_q];
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: capture latency, fill/overrun, push+pop at full, wrap, reset mid-capture.
module tb_uart_rx_fifo;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_pass;

  uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2 (4),
    .IRQ_THRESH (4),
    .TIMEOUT_CYC(16'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

`ifdef UART_RXFIFO_THRESH_EN
  localparam logic IRQ_ONE_BYTE = 1'b0;
`else
  localparam logic IRQ_ONE_BYTE = 1'b1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_rs = 1'b0;
    bus.rd_en = 1'b0;
    bus.ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Holds rx_rs until over_read is seen, then releases it and lets the FSM return to idle.
  task automatic send_byte(input logic [7:0] b);
    bit acked;
    acked = 1'b0;
    bus.rx_data = b;
    bus.rx_rs = 1'b1;
    for (int k = 0; k < 10 && !acked; k++) begin
      @(negedge clk);
      if (bus.over_read === 1'b1) acked = 1'b1;
    end
    bus.rx_rs = 1'b0;
    n_checks++;
    if (!acked) $display("FAIL send_ack: no over_read for byte %02h", b);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_rs = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_en = 1'b0;
    bus.ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.over_read !== 1'b0) $display("FAIL rst_over_read: got %b want 0", bus.over_read); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", bus.empty); else n_pass++;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL rst_full: got %b want 0", bus.full); else n_pass++;
    n_checks++; if (bus.count !== 5'd0) $display("FAIL rst_count: got %0d want 0", bus.count); else n_pass++;
    n_checks++; if (bus.overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", bus.overrun); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", bus.irq); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    bus.rx_data = 8'hA5;
    bus.rx_rs = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.over_read !== 1'b0) $display("FAIL lat_edge1: over_read got %b want 0", bus.over_read); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.over_read !== 1'b0) $display("FAIL lat_edge2: over_read got %b want 0", bus.over_read); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.over_read !== 1'b1) $display("FAIL lat_edge3: over_read got %b want 1", bus.over_read); else n_pass++;
    n_checks++; if (bus.count !== 5'd1) $display("FAIL single_count: got %0d want 1", bus.count); else n_pass++;
    bus.rx_rs = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.over_read !== 1'b0) $display("FAIL pulse_width: over_read got %b want 0", bus.over_read); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.rd_data !== 8'hA5) $display("FAIL single_data: got %02h want a5", bus.rd_data); else n_pass++;
    n_checks++; if (bus.empty !== 1'b0) $display("FAIL single_empty: got %b want 0", bus.empty); else n_pass++;
    n_checks++; if (bus.irq !== IRQ_ONE_BYTE) $display("FAIL single_irq: got %b want %b", bus.irq, IRQ_ONE_BYTE); else n_pass++;
    pop_one();
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL pop_empty: got %b want 1", bus.empty); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL pop_irq: got %b want 0", bus.irq); else n_pass++;
    pop_one();
    n_checks++; if (bus.count !== 5'd0) $display("FAIL pop_when_empty: count got %0d want 0", bus.count); else n_pass++;
  endtask

  task automatic test_fill_overrun();
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    n_checks++; if (bus.full !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.full); else n_pass++;
    n_checks++; if (bus.count !== 5'd16) $display("FAIL fill_count: got %0d want 16", bus.count); else n_pass++;
    n_checks++; if (bus.overrun !== 1'b0) $display("FAIL fill_no_ovr: got %b want 0", bus.overrun); else n_pass++;
    send_byte(8'hFF);
    n_checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", bus.overrun); else n_pass++;
    n_checks++; if (bus.count !== 5'd16) $display("FAIL ovr_count: got %0d want 16", bus.count); else n_pass++;
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL ovr_irq: got %b want 1", bus.irq); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.rd_data !== 8'(i)) $display("FAIL fill_order[%0d]: got %02h want %02h", i, bus.rd_data, 8'(i)); else n_pass++;
      pop_one();
    end
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", bus.empty); else n_pass++;
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL drain_irq_sticky: got %b want 1", bus.irq); else n_pass++;
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    n_checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clr: got %b want 0", bus.overrun); else n_pass++;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL clr_irq: got %b want 0", bus.irq); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    bus.rx_data = 8'hAB;
    bus.rx_rs = 1'b1;
    repeat (2) @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.rx_rs = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'hAB);
    n_checks++; if (bus.over_read !== 1'b1) $display("FAIL ppf_ack: over_read got %b want 1", bus.over_read); else n_pass++;
    n_checks++; if (bus.count !== 5'd16) $display("FAIL ppf_count: got %0d want 16", bus.count); else n_pass++;
    n_checks++; if (bus.overrun !== 1'b0) $display("FAIL ppf_overrun: got %b want 0", bus.overrun); else n_pass++;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.rd_data !== exp_q[i]) $display("FAIL ppf_order[%0d]: got %02h want %02h", i, bus.rd_data, exp_q[i]); else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_wrap();
    int max_cnt;
    max_cnt = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_byte(8'(8'h40 + i));
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      n_checks++; if (bus.rd_data !== 8'(8'h40 + i)) $display("FAIL wrap_data[%0d]: got %02h want %02h", i, bus.rd_data, 8'(8'h40 + i)); else n_pass++;
      pop_one();
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end
    n_checks++; if (max_cnt !== 1) $display("FAIL wrap_max_count: got %0d want 1", max_cnt); else n_pass++;
    n_checks++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", bus.empty); else n_pass++;
  endtask

  task automatic test_reset_mid_capture();
    bit seen;
    int pulses;
    do_reset();
    seen = 1'b0;
    bus.rx_data = 8'h5C;
    bus.rx_rs = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.over_read === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL mid_reach_ack: over_read got 0 want 1"); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.over_read !== 1'b0) $display("FAIL mid_over_read: got %b want 0", bus.over_read); else n_pass++;
    n_checks++; if (bus.count !== 5'd0) $display("FAIL mid_count: got %0d want 0", bus.count); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL mid_state: got %0d want 0", dbg_state); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.over_read === 1'b1) begin
        pulses++;
        bus.rx_rs = 1'b0;
      end
    end
    n_checks++; if (pulses !== 1) $display("FAIL mid_recapture: pulses got %0d want 1", pulses); else n_pass++;
    n_checks++; if (bus.count !== 5'd1) $display("FAIL mid_recount: got %0d want 1", bus.count); else n_pass++;
    n_checks++; if (bus.rd_data !== 8'h5C) $display("FAIL mid_data: got %02h want 5c", bus.rd_data); else n_pass++;
  endtask

`ifdef UART_RXFIFO_THRESH_EN
  task automatic test_thresh_timeout();
    int k;
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h70 + i));
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL thr_below: got %b want 0", bus.irq); else n_pass++;
    k = 0;
    while (bus.irq !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k !== 96) $display("FAIL thr_timeout: cycles got %0d want 96", k); else n_pass++;
    pop_one();
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL thr_pop_rearm: got %b want 0", bus.irq); else n_pass++;
    send_byte(8'h73);
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL thr_three: got %b want 0", bus.irq); else n_pass++;
    send_byte(8'h74);
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL thr_four: got %b want 1", bus.irq); else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_rs = 1'b0;
    bus.rd_en = 1'b0;
    bus.ovr_clr = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_overrun();
    test_push_pop_full();
    test_wrap();
    test_reset_mid_capture();
`ifdef UART_RXFIFO_THRESH_EN
    test_thresh_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
